// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer: pops entries from the upstream FIFO and packs PACK of them
// into one wide word on a valid/ready output. A flush emits the partial word.
//
// state | meaning
// FILL  | popping entries and capturing them into lanes, handling flush
// DRAIN | packed word presented on out_valid, waiting for out_ready
`timescale 1ns/1ps
module fifo_drain_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int CNT_WIDTH  = $clog2(PACK + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fifo_empty,
  input  logic [DATA_WIDTH-1:0]        fifo_data,
  output logic                         fifo_rd_enable,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*PACK-1:0]   out_data,
  output logic [CNT_WIDTH-1:0]         out_count,
  output logic                         busy
);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  localparam logic [CNT_WIDTH:0]   PACK_EXT  = (CNT_WIDTH + 1)'(PACK);
  localparam logic [CNT_WIDTH-1:0] PACK_CNT  = CNT_WIDTH'(PACK);
  localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(PACK - 1);

  state_t                       state;
  logic [CNT_WIDTH-1:0]         fill;
  logic                         pend;
  logic                         flush_req;
  logic [DATA_WIDTH*PACK-1:0]   lanes;
  logic [CNT_WIDTH:0]           fill_pend;

  // Entries already captured plus the one still in flight; one extra bit so it cannot wrap.
  assign fill_pend = {1'b0, fill} + {{CNT_WIDTH{1'b0}}, pend};

  // Pops stop once the in-flight entry would complete the word, so back-to-back pops never overfill.
  assign fifo_rd_enable = (state == FILL) & ~fifo_empty & ~flush_req & (fill_pend < PACK_EXT);

  assign out_data = lanes;
  assign busy     = (fill != '0) | pend | flush_req | (state == DRAIN);

  // Pop tracking, lane capture, flush handling and output hand-off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      fill      <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      lanes     <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
    end else begin
      // FIFO data shows up the cycle after the pop, so remember that a pop happened.
      pend <= fifo_rd_enable & ~fifo_empty;
      if (flush) flush_req <= 1'b1;
      case (state)
        FILL: begin
          if (pend) begin
            for (int i = 0; i < PACK; i++) begin
              if (fill == CNT_WIDTH'(i)) lanes[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
            end
            fill <= fill + CNT_WIDTH'(1);
            if (fill == LAST_LANE) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_count <= PACK_CNT;
            end
          end else if (flush_req) begin
            // A flush with nothing captured simply retires without emitting a word.
            flush_req <= 1'b0;
            if (fill != '0) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_count <= fill;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state     <= FILL;
            fill      <= '0;
            lanes     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer with a behavioural registered-output FIFO.
`timescale 1ns/1ps
module tb_fifo_drain_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_enable;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        busy;

  logic [7:0]  mem [0:63];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          errors = 0;
  int          checks = 0;

  fifo_drain_packer #(.DATA_WIDTH(8), .PACK(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_enable(fifo_rd_enable), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO model: combinational empty, data registered one cycle after the pop.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_enable && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk); #1;
      if (out_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (fifo_rd_enable !== 1'b0) begin errors++; $display("FAIL reset_rd_enable got=%b want=0", fifo_rd_enable); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_out_count got=%0d want=0", out_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_single_word();
    int rd_cnt, v_cnt;
    logic [31:0] data;
    logic [2:0]  cnt;
    rd_cnt = 0; v_cnt = 0; data = '0; cnt = '0;
    @(negedge clk);
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int i = 0; i < 12; i++) begin
      #1;
      if (fifo_rd_enable === 1'b1) rd_cnt++;
      if (out_valid === 1'b1) begin v_cnt++; data = out_data; cnt = out_count; end
      @(negedge clk);
    end
    #1;
    checks++; if (rd_cnt != 4) begin errors++; $display("FAIL single_rd_cycles got=%0d want=4", rd_cnt); end
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL single_valid_cycles got=%0d want=1", v_cnt); end
    checks++; if (data !== 32'h44332211) begin errors++; $display("FAIL single_data got=%h want=44332211", data); end
    checks++; if (cnt !== 3'd4) begin errors++; $display("FAIL single_count got=%0d want=4", cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_first_valid got=timeout want=out_valid"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_count !== 3'd4 || fifo_rd_enable !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d got valid=%b data=%h count=%0d rd=%b want 1 04030201 4 0",
                 i, out_valid, out_data, out_count, fifo_rd_enable);
      end
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept_drop got=%b want=0", out_valid); end
    wait_valid(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_second_valid got=timeout want=out_valid"); end
    checks++; if (out_data !== 32'h08070605) begin errors++; $display("FAIL bp_second_data got=%h want=08070605", out_data); end
    checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL bp_second_count got=%0d want=4", out_count); end
    @(negedge clk); #1;
  endtask

  task automatic test_flush_partial();
    bit ok;
    @(negedge clk);
    push(8'hAA); push(8'hBB);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_valid got=timeout want=out_valid"); end
    checks++; if (out_data !== 32'h0000BBAA) begin errors++; $display("FAIL flush_data got=%h want=0000bbaa", out_data); end
    checks++; if (out_count !== 3'd2) begin errors++; $display("FAIL flush_count got=%0d want=2", out_count); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_done got valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_flush_empty();
    int v_cnt;
    v_cnt = 0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    if (out_valid === 1'b1) v_cnt++;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL empty_flush_busy_set got=%b want=1", busy); end
    @(negedge clk); #1;
    if (out_valid === 1'b1) v_cnt++;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_flush_busy_clear got=%b want=0", busy); end
    @(negedge clk); #1;
    if (out_valid === 1'b1) v_cnt++;
    checks++; if (v_cnt != 0) begin errors++; $display("FAIL empty_flush_no_word got=%0d valid cycles want=0", v_cnt); end
  endtask

  task automatic test_flush_with_pop();
    bit ok;
    @(negedge clk);
    push(8'hDD);
    repeat (3) @(negedge clk);
    push(8'hCC);
    flush = 1'b1;
    #1;
    checks++; if (fifo_rd_enable !== 1'b1) begin errors++; $display("FAIL pop_flush_rd got=%b want=1", fifo_rd_enable); end
    @(negedge clk);
    flush = 1'b0;
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL pop_flush_valid got=timeout want=out_valid"); end
    checks++; if (out_data !== 32'h0000CCDD) begin errors++; $display("FAIL pop_flush_data got=%h want=0000ccdd", out_data); end
    checks++; if (out_count !== 3'd2) begin errors++; $display("FAIL pop_flush_count got=%0d want=2", out_count); end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    @(negedge clk);
    push(8'h51); push(8'h52);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== 3'd0 || busy !== 1'b0 || fifo_rd_enable !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs got valid=%b data=%h count=%0d busy=%b rd=%b want all 0",
               out_valid, out_data, out_count, busy, fifo_rd_enable);
    end
    @(negedge clk);
    reset = 1'b1;
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    wait_valid(12, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_valid got=timeout want=out_valid"); end
    checks++; if (out_data !== 32'h64636261) begin errors++; $display("FAIL midrst_data got=%h want=64636261", out_data); end
    checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL midrst_count got=%0d want=4", out_count); end
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_flush_partial();
    test_flush_empty();
    test_flush_with_pop();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
